// File: rtl/hack_mem_bridge_if.sv
// Memory-request bus between hack_mem_bridge and the SDRAM request FIFO / read-return path.
interface hack_mem_bridge_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, wdata, we, input ready, rvalid, rdata);
  modport slave  (input req, addr, wdata, we, output ready, rvalid, rdata);
endinterface

// File: rtl/hack_mem_bridge.sv
// Paced Hack CPU-to-memory bridge: clock-enable stepping, SDRAM read/write requests, local MMIO.
// Optional read watchdog enabled by defining HMB_TIMEOUT_EN.
module hack_mem_bridge #(
  parameter int unsigned       ADDR_W      = 15,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       DIV_LOG2    = 11,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = ADDR_W'('h6000),
  parameter int unsigned       TIMEOUT_CYC = 1024
) (
  input  logic                clk50,
  input  logic                reset,
  input  logic                hlt,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_dout,
  input  logic                cpu_we,
  output logic [DATA_W-1:0]   cpu_din,
  output logic                cpu_ce,
  hack_mem_bridge_if.master   mem,
  input  logic [3:0]          key,
  output logic [15:0]         seg_num,
  output logic [3:0]          led,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    SETTLE  = 3'd3,
    WR_REQ  = 3'd4,
    STEP    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_LOG2-1:0] div_q, div_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                req_q, req_d;
  logic                ce_q, ce_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [15:0]         seg_q, seg_d;
  logic [3:0]          led_q, led_d;

  logic                div_full_c;
  logic                mmio_c;
  logic [ADDR_W-1:0]   mmio_off_c;
  logic [DATA_W-1:0]   mmio_rdata_c;
  logic                tmo_hit_c;

  assign div_full_c = (div_q == {DIV_LOG2{1'b1}});
  // Decode always uses the latched address, never the live CPU bus.
  assign mmio_c     = (addr_q >= MMIO_BASE);
  assign mmio_off_c = addr_q - MMIO_BASE;

  always_comb begin
    mmio_rdata_c = '0;
    if (mmio_off_c == ADDR_W'(0))      mmio_rdata_c = DATA_W'(seg_q);
    else if (mmio_off_c == ADDR_W'(1)) mmio_rdata_c = DATA_W'(led_q);
    else if (mmio_off_c == ADDR_W'(2)) mmio_rdata_c = DATA_W'(key);
  end

`ifdef HMB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  assign tmo_hit_c = (state_q == RD_WAIT) && !mem.rvalid &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    err_d = err_q | tmo_hit_c;
    if (state_q == RD_WAIT) tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit_c = 1'b0;
  assign err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (div_full_c && !hlt) state_d = RD_REQ;
      RD_REQ:  if (mmio_c) state_d = SETTLE;
               else if (mem.ready) state_d = RD_WAIT;
      RD_WAIT: if (mem.rvalid || tmo_hit_c) state_d = SETTLE;
      SETTLE:  state_d = cpu_we ? WR_REQ : STEP;
      WR_REQ:  if (mmio_c || mem.ready) state_d = STEP;
      STEP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; every output is registered below
  always_comb begin
    div_d   = div_full_c ? div_q : div_q + DIV_LOG2'(1);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    req_d   = 1'b0;
    ce_d    = (state_d == STEP);
    din_d   = din_q;
    seg_d   = seg_q;
    led_d   = led_q;
    case (state_q)
      IDLE: begin
        if (state_d == RD_REQ) begin
          addr_d = cpu_addr;
          we_d   = 1'b0;
        end
      end
      RD_REQ: begin
        if (mmio_c) din_d = mmio_rdata_c;
        else        req_d = (state_d == RD_WAIT);
      end
      RD_WAIT: begin
        if (mem.rvalid)     din_d = mem.rdata;
        else if (tmo_hit_c) din_d = '1;
      end
      SETTLE: begin
        if (cpu_we) begin
          wdata_d = cpu_dout;
          we_d    = 1'b1;
        end
      end
      WR_REQ: begin
        if (mmio_c) begin
          if (mmio_off_c == ADDR_W'(0))      seg_d = 16'(wdata_q);
          else if (mmio_off_c == ADDR_W'(1)) led_d = wdata_q[3:0];
        end else begin
          req_d = mem.ready;
        end
      end
      STEP:    div_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      ce_q    <= 1'b0;
      din_q   <= '0;
      seg_q   <= '0;
      led_q   <= '0;
    end else begin
      div_q   <= div_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      ce_q    <= ce_d;
      din_q   <= din_d;
      seg_q   <= seg_d;
      led_q   <= led_d;
    end
  end

  assign mem.req   = req_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign mem.we    = we_q;
  assign cpu_din   = din_q;
  assign cpu_ce    = ce_q;
  assign seg_num   = seg_q;
  assign led       = led_q;

endmodule

// File: tb/tb_hack_mem_bridge.sv
// Directed scoreboard bench for hack_mem_bridge (DIV_LOG2=2, TIMEOUT_CYC=8).
module tb_hack_mem_bridge;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
  } req_t;

  logic              clk50 = 1'b0;
  logic              reset = 1'b1;
  logic              hlt   = 1'b1;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_we = 1'b0;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_ce;
  logic [3:0]        key = 4'h0;
  logic [15:0]       seg_num;
  logic [3:0]        led;
  logic              err;

  logic              dout_inc = 1'b0;
  logic [DATA_W-1:0] dout_val = '0;

  req_t              exp_q[$], obs_q[$];
  logic [DATA_W-1:0] exp_din[$], obs_din[$];
  int                tests = 0, failed = 0;
  int                cyc = 0, ce_cnt = 0, ce_cyc = 0, rv_cyc = 0;
  int                rcnt = 0, rd_lat = 3;
  logic              rsp_en = 1'b1;
  logic [DATA_W-1:0] rd_val = '0;

  always #10 clk50 = ~clk50;

  hack_mem_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  hack_mem_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_LOG2(2),
    .MMIO_BASE(15'h6000), .TIMEOUT_CYC(8)
  ) dut (
    .clk50(clk50), .reset(reset), .hlt(hlt),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .cpu_din(cpu_din), .cpu_ce(cpu_ce), .mem(mem_if),
    .key(key), .seg_num(seg_num), .led(led), .err(err)
  );

  // CPU outM model: either a constant or M+1 of the returned inM
  always_comb cpu_dout = dout_inc ? cpu_din + 16'd1 : dout_val;

  always @(posedge clk50) cyc <= cyc + 1;

  always @(negedge clk50) begin
    if (!reset) begin
      if (mem_if.req)
        obs_q.push_back(req_t'{mem_if.addr, mem_if.we ? mem_if.wdata : 16'h0, mem_if.we});
      if (cpu_ce) begin
        ce_cnt++;
        ce_cyc = cyc;
        obs_din.push_back(cpu_din);
      end
    end
  end

  // Read responder: returns rd_val rd_lat cycles after a read request
  always @(negedge clk50) begin
    mem_if.rvalid = 1'b0;
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        mem_if.rvalid = 1'b1;
        mem_if.rdata  = rd_val;
        rv_cyc        = cyc;
      end
    end
    if (!reset && rsp_en && mem_if.req && !mem_if.we) rcnt = rd_lat;
  end

  task automatic tick();
    @(negedge clk50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_wait(input string tag);
    int start;
    start = ce_cnt;
    hlt = 1'b0;
    for (int i = 0; i < 300 && ce_cnt == start; i++) tick();
    hlt = 1'b1;
    chk({tag, "_ce"}, 64'(ce_cnt - start), 64'd1);
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_nreq"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_req"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    chk({tag, "_ndin"}, 64'(obs_din.size()), 64'(exp_din.size()));
    while (obs_din.size() > 0 && exp_din.size() > 0)
      chk({tag, "_din"}, 64'(obs_din.pop_front()), 64'(exp_din.pop_front()));
    obs_q.delete(); exp_q.delete(); obs_din.delete(); exp_din.delete();
  endtask

  initial begin
    int start;
    mem_if.ready = 1'b1;
    tick(); tick();
    chk("rst_bus", 64'({cpu_din, mem_if.addr, mem_if.wdata, mem_if.we, cpu_ce, mem_if.req}), 64'd0);
    chk("rst_mmio", 64'({seg_num, led, err}), 64'd0);
    reset = 1'b0;
    tick();

    // 1: plain read, one SETTLE cycle between rvalid and cpu_ce
    cpu_addr = 15'h0010; cpu_we = 1'b0; rd_val = 16'h1234; rd_lat = 3;
    exp_q.push_back(req_t'{15'h0010, 16'h0, 1'b0}); exp_din.push_back(16'h1234);
    step_wait("t1");
    chk("t1_settle", 64'(ce_cyc - rv_cyc), 64'd2);
    check_sb("t1");

    // 2: M=M+1 -> read then posted write of 6
    cpu_addr = 15'h0020; cpu_we = 1'b1; dout_inc = 1'b1; rd_val = 16'd5;
    exp_q.push_back(req_t'{15'h0020, 16'h0, 1'b0});
    exp_q.push_back(req_t'{15'h0020, 16'd6, 1'b1});
    exp_din.push_back(16'd5);
    step_wait("t2");
    chk("t2_lat", 64'(ce_cyc - rv_cyc), 64'd3);
    check_sb("t2");
    tick();
    chk("t2_hold", 64'({mem_if.addr, mem_if.wdata, mem_if.we}), 64'({15'h0020, 16'd6, 1'b1}));

    // 3: MMIO writes/reads, no memory traffic
    dout_inc = 1'b0; key = 4'b1010;
    cpu_addr = 15'h6000; cpu_we = 1'b1; dout_val = 16'hBEEF; exp_din.push_back(16'h0000); step_wait("t3a");
    cpu_addr = 15'h6001; dout_val = 16'h0003;               exp_din.push_back(16'h0000); step_wait("t3b");
    cpu_addr = 15'h6002; dout_val = 16'hFFFF;               exp_din.push_back(16'h000A); step_wait("t3c");
    cpu_we = 1'b0;
    cpu_addr = 15'h6005; exp_din.push_back(16'h0000); step_wait("t3d");
    cpu_addr = 15'h6000; exp_din.push_back(16'hBEEF); step_wait("t3e");
    check_sb("t3");
    chk("t3_seg", 64'(seg_num), 64'hBEEF);
    chk("t3_led", 64'(led), 64'h3);

    // 4: hlt holds at terminal count, then mem_ready=0 stalls RD_REQ
    cpu_addr = 15'h0100; rd_val = 16'h0F0F;
    start = ce_cnt;
    repeat (10) tick();
    chk("t4_hlt", 64'({obs_q.size(), ce_cnt - start}), 64'd0);
    mem_if.ready = 1'b0; hlt = 1'b0;
    repeat (12) tick();
    chk("t4_stall", 64'({obs_q.size(), ce_cnt - start}), 64'd0);
    mem_if.ready = 1'b1;
    exp_q.push_back(req_t'{15'h0100, 16'h0, 1'b0}); exp_din.push_back(16'h0F0F);
    step_wait("t4");
    check_sb("t4");

    // 5: reset during RD_WAIT, late rvalid, then clean restart
    cpu_addr = 15'h0040; rd_val = 16'h7777; rd_lat = 6;
    hlt = 1'b0;
    for (int i = 0; i < 50 && obs_q.size() == 0; i++) tick();
    exp_q.push_back(req_t'{15'h0040, 16'h0, 1'b0});
    check_sb("t5_pre");
    tick();
    hlt = 1'b1; reset = 1'b1; start = ce_cnt;
    tick();
    chk("t5_rst_bus", 64'({cpu_din, mem_if.addr, mem_if.wdata, mem_if.we, cpu_ce, mem_if.req}), 64'd0);
    chk("t5_rst_mmio", 64'({seg_num, led}), 64'd0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("t5_late", 64'({cpu_din, 16'(obs_q.size()), 16'(ce_cnt - start)}), 64'd0);
    cpu_addr = 15'h0050; rd_val = 16'hA5A5; rd_lat = 3;
    exp_q.push_back(req_t'{15'h0050, 16'h0, 1'b0}); exp_din.push_back(16'hA5A5);
    step_wait("t5");
    check_sb("t5");

`ifdef HMB_TIMEOUT_EN
    // 6: no read data -> watchdog returns all ones and flags err
    rsp_en = 1'b0; cpu_addr = 15'h0060;
    exp_q.push_back(req_t'{15'h0060, 16'h0, 1'b0}); exp_din.push_back(16'hFFFF);
    step_wait("t6");
    check_sb("t6");
    chk("t6_err", 64'(err), 64'd1);
    rsp_en = 1'b1;
`else
    chk("err_tied", 64'(err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
